// File: rtl/uart_16550_regs_pkg.sv
// Register map, LSR bit positions, AXI widths and sequencer state encoding
// shared by the uart_16550 register-port sequencer and its AXI engine.
package uart_16550_regs_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // DLL/DLM alias RBR_THR/IER_DLM while LCR[7] is set.
    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER_DLM = 3'd1;
    localparam logic [2:0] FCR     = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] LSR     = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_POLL_WAIT = 3'd2,
        ST_POLL_RD   = 3'd3,
        ST_TX_WR     = 3'd4,
        ST_RX_RD     = 3'd5
    } uart_seq_state_t;

endpackage

// File: rtl/axil_master_single.sv
// Single-outstanding AXI4-Lite master: one byte-wide register read or write
// per request, with done/err/rdata8 reported combinationally on the final handshake.
module axil_master_single
    import uart_16550_regs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [AXI_ADDR_W-1:0]     addr,
    input  logic [7:0]                wdata8,
    output logic                      done,
    output logic [7:0]                rdata8,
    output logic                      err,
    output logic                      busy,
    output logic [AXI_ADDR_W-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DATA_W-1:0]     m_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic [AXI_ADDR_W-1:0]     m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_W-1:0]     m_rdata,
    input  logic                      m_rvalid,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready
);

    logic                  aw_q, w_q, b_q, ar_q, r_q, busy_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [7:0]            wdata_q;
    logic                  aw_ok, w_ok, b_hs, r_hs;
    logic                  unused_rdata_hi;

    // A beat transfers on a cycle where valid && ready; each valid is held
    // until its own ready and never re-raised within the same transaction.
    assign aw_ok = !aw_q || m_awready;
    assign w_ok  = !w_q || m_wready;
    assign b_hs  = b_q && m_bvalid;
    assign r_hs  = r_q && m_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            b_q     <= 1'b0;
            ar_q    <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
        end else begin
            if (!busy_q && req) begin
                busy_q  <= 1'b1;
                addr_q  <= addr;
                wdata_q <= wdata8;
                aw_q    <= we;
                w_q     <= we;
                ar_q    <= !we;
            end
            if (aw_q && m_awready) aw_q <= 1'b0;
            if (w_q && m_wready)   w_q  <= 1'b0;
            // bready rises on the cycle the later of AW/W completes.
            if ((aw_q || w_q) && aw_ok && w_ok) b_q <= 1'b1;
            if (b_hs) begin
                b_q    <= 1'b0;
                busy_q <= 1'b0;
            end
            if (ar_q && m_arready) begin
                ar_q <= 1'b0;
                r_q  <= 1'b1;
            end
            if (r_hs) begin
                r_q    <= 1'b0;
                busy_q <= 1'b0;
            end
        end
    end

    assign done            = b_hs || r_hs;
    assign err             = (b_hs && (m_bresp != RESP_OKAY)) || (r_hs && (m_rresp != RESP_OKAY));
    assign rdata8          = m_rdata[7:0];
    assign unused_rdata_hi = ^m_rdata[AXI_DATA_W-1:8];
    assign busy            = busy_q;

    assign m_awaddr  = addr_q;
    assign m_awvalid = aw_q;
    assign m_wdata   = {{(AXI_DATA_W-8){1'b0}}, wdata_q};
    assign m_wstrb   = {{(AXI_DATA_W/8-1){1'b0}}, 1'b1};
    assign m_wvalid  = w_q;
    assign m_bready  = b_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = ar_q;
    assign m_rready  = r_q;

endmodule

// File: rtl/uart_axil_sequencer.sv
// Configures a uart_16550 over AXI4-Lite, then polls LSR and shuttles bytes
// between the local tx/rx byte streams and THR/RBR.
module uart_axil_sequencer
    import uart_16550_regs_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                    ADDR_SHIFT = 2,
    parameter int                    POLL_GAP   = 8,
    parameter logic [7:0]            FCR_VAL    = 8'h07
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic [15:0]               cfg_divisor,
    input  logic [7:0]                cfg_lcr,
    output logic                      cfg_done,
    output logic                      busy,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [3:0]                lsr_err,
    output logic                      bus_err,
    input  logic                      err_clr,
    output logic [2:0]                dbg_state,
    output logic [AXI_ADDR_W-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DATA_W-1:0]     m_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic [AXI_ADDR_W-1:0]     m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_W-1:0]     m_rdata,
    input  logic                      m_rvalid,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    uart_seq_state_t state_q;
    logic [2:0]      step_q, idx_q, cfg_idx, iss_idx;
    logic [7:0]      wdata_q, cfg_data, iss_data, lcr_q, rx_data_q;
    logic [15:0]     div_q, gap_q;
    logic [3:0]      lsr_err_q;
    logic            pend_q, req_q, we_q, cfg_pend_q, cfg_done_q;
    logic            tx_ready_q, rx_valid_q, bus_err_q;
    logic            iss_we, txn_state, restart;
    logic            mst_done, mst_err;
    logic [7:0]      mst_rdata;

    always_comb begin
        cfg_idx  = LCR;
        cfg_data = 8'h80 | lcr_q;
        case (step_q)
            3'd1:    begin cfg_idx = RBR_THR; cfg_data = div_q[7:0];  end
            3'd2:    begin cfg_idx = IER_DLM; cfg_data = div_q[15:8]; end
            3'd3:    begin cfg_idx = LCR;     cfg_data = lcr_q;       end
            3'd4:    begin cfg_idx = FCR;     cfg_data = FCR_VAL;     end
            3'd5:    begin cfg_idx = IER_DLM; cfg_data = 8'h00;       end
            default: ;
        endcase
    end

    always_comb begin
        iss_we   = 1'b0;
        iss_idx  = LSR;
        iss_data = 8'h00;
        case (state_q)
            ST_CFG:   begin iss_we = 1'b1; iss_idx = cfg_idx; iss_data = cfg_data; end
            ST_TX_WR: begin iss_we = 1'b1; iss_idx = RBR_THR; iss_data = tx_data;  end
            ST_RX_RD: iss_idx = RBR_THR;
            default:  ;
        endcase
    end

    assign txn_state = (state_q == ST_CFG) || (state_q == ST_POLL_RD) ||
                       (state_q == ST_TX_WR) || (state_q == ST_RX_RD);
    assign restart   = cfg_pend_q || cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            idx_q      <= 3'd0;
            wdata_q    <= 8'h00;
            lcr_q      <= 8'h00;
            div_q      <= 16'h0000;
            gap_q      <= 16'h0000;
            pend_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            cfg_pend_q <= 1'b0;
            cfg_done_q <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            lsr_err_q  <= 4'h0;
            bus_err_q  <= 1'b0;
        end else begin
            req_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            if (cfg_start) begin
                cfg_pend_q <= 1'b1;
                cfg_done_q <= 1'b0;
                div_q      <= cfg_divisor;
                lcr_q      <= {1'b0, cfg_lcr[6:0]};
            end
            if (txn_state && !pend_q) begin
                pend_q  <= 1'b1;
                req_q   <= 1'b1;
                we_q    <= iss_we;
                idx_q   <= iss_idx;
                wdata_q <= iss_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_q    <= ST_CFG;
                        step_q     <= 3'd0;
                        cfg_pend_q <= 1'b0;
                    end
                end
                ST_POLL_WAIT: begin
                    if (restart) begin
                        state_q    <= ST_CFG;
                        step_q     <= 3'd0;
                        cfg_pend_q <= 1'b0;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= ST_POLL_RD;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: begin
                    if (mst_done) begin
                        pend_q <= 1'b0;
                        if (mst_err) bus_err_q <= 1'b1;
                        // Completion side effects stand even if a restart follows.
                        if (state_q == ST_TX_WR) tx_ready_q <= 1'b1;
                        if (state_q == ST_RX_RD && !mst_err) begin
                            rx_data_q  <= mst_rdata;
                            rx_valid_q <= 1'b1;
                        end
                        if (state_q == ST_POLL_RD && !mst_err)
                            lsr_err_q <= lsr_err_q | mst_rdata[LSR_BI:LSR_OE];
                        if (restart) begin
                            state_q    <= ST_CFG;
                            step_q     <= 3'd0;
                            cfg_pend_q <= 1'b0;
                        end else if (state_q == ST_CFG) begin
                            if (step_q == 3'd5) begin
                                cfg_done_q <= 1'b1;
                                state_q    <= ST_POLL_RD;
                            end else begin
                                step_q <= step_q + 3'd1;
                            end
                        end else if (state_q == ST_POLL_RD) begin
                            if (!mst_err && mst_rdata[LSR_DR] && !rx_valid_q) begin
                                state_q <= ST_RX_RD;
                            end else if (!mst_err && mst_rdata[LSR_THRE] && tx_valid) begin
                                state_q <= ST_TX_WR;
                            end else if (POLL_GAP == 0) begin
                                state_q <= ST_POLL_RD;
                            end else begin
                                state_q <= ST_POLL_WAIT;
                                gap_q   <= 16'h0000;
                            end
                        end else begin
                            state_q <= ST_POLL_RD;
                        end
                    end
                end
            endcase
            if (err_clr) begin
                lsr_err_q <= 4'h0;
                bus_err_q <= 1'b0;
            end
        end
    end

    axil_master_single u_mst (
        .clk       (clk),
        .rst       (rst),
        .req       (req_q),
        .we        (we_q),
        .addr      (BASE_ADDR + (AXI_ADDR_W'(idx_q) << ADDR_SHIFT)),
        .wdata8    (wdata_q),
        .done      (mst_done),
        .rdata8    (mst_rdata),
        .err       (mst_err),
        .busy      (busy),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bresp   (m_bresp),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_rresp   (m_rresp),
        .m_rready  (m_rready)
    );

    assign cfg_done  = cfg_done_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign lsr_err   = lsr_err_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_axil_sequencer.sv
// Directed bench: a negedge-driven uart_16550 AXI slave model logs every
// register write into a queue that is checked against hand-built expectations.
module tb_uart_axil_sequencer;

    localparam int W = 11;

    logic        clk, rst;
    logic        cfg_start, cfg_done, busy;
    logic [15:0] cfg_divisor;
    logic [7:0]  cfg_lcr, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [3:0]  lsr_err;
    logic        bus_err, err_clr;
    logic [2:0]  dbg_state;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    // slave model knobs (written by the main sequence only)
    logic [7:0]  lsr_val, rbr_val;
    logic [1:0]  next_bresp;
    int          aw_delay, w_delay, b_delay;

    // slave model state and logs (written by the slave process only)
    logic [W-1:0] got_q[$];
    logic         have_aw, have_w, have_ar;
    logic [2:0]   aw_idx, ar_idx;
    logic [7:0]   w_byte;
    int           aw_wait, w_wait, b_wait;
    int           aw_beats, w_beats, lsr_reads, rbr_reads, wfmt_bad;

    logic [W-1:0] exp_q[$];
    int           got_rd;
    int           n_checks, n_bad, tx_pulses;
    int           a0, w0, r0, l0, t0, busy_low;

    uart_axil_sequencer dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_divisor(cfg_divisor),
        .cfg_lcr(cfg_lcr), .cfg_done(cfg_done), .busy(busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .lsr_err(lsr_err), .bus_err(bus_err), .err_clr(err_clr),
        .dbg_state(dbg_state),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (tx_ready) tx_pulses++;

    // AXI slave: decides ready/valid at negedge for the following posedge
    initial begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
        have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
        aw_idx = 3'd0; ar_idx = 3'd0; w_byte = 8'h00;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_beats = 0; w_beats = 0; lsr_reads = 0; rbr_reads = 0; wfmt_bad = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
                aw_wait = 0; w_wait = 0; b_wait = 0;
                m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
                m_arready = 1'b0; m_rvalid = 1'b0;
            end else begin
                m_bvalid = 1'b0;
                if (have_aw && have_w) begin
                    if (b_wait < b_delay) begin
                        b_wait++;
                    end else begin
                        m_bvalid = 1'b1;
                        m_bresp  = next_bresp;
                        if (m_bready) begin
                            got_q.push_back({aw_idx, w_byte});
                            have_aw = 1'b0; have_w = 1'b0; b_wait = 0;
                        end
                    end
                end
                m_rvalid = 1'b0;
                if (have_ar) begin
                    m_rvalid = 1'b1;
                    m_rdata  = (ar_idx == 3'd5) ? {24'h0, lsr_val} :
                               (ar_idx == 3'd0) ? {24'h0, rbr_val} : 32'h0;
                    if (m_rready) begin
                        have_ar = 1'b0;
                        if (ar_idx == 3'd5) lsr_reads++;
                        else if (ar_idx == 3'd0) rbr_reads++;
                    end
                end
                m_awready = 1'b0;
                if (m_awvalid && !have_aw) begin
                    if (aw_wait >= aw_delay) begin
                        m_awready = 1'b1; have_aw = 1'b1; aw_idx = m_awaddr[4:2];
                        aw_beats++; aw_wait = 0;
                    end else aw_wait++;
                end
                m_wready = 1'b0;
                if (m_wvalid && !have_w) begin
                    if (w_wait >= w_delay) begin
                        m_wready = 1'b1; have_w = 1'b1; w_byte = m_wdata[7:0];
                        if (m_wstrb != 4'b0001 || m_wdata[31:8] != 24'h0) wfmt_bad++;
                        w_beats++; w_wait = 0;
                    end else w_wait++;
                end
                m_arready = 1'b0;
                if (m_arvalid && !have_ar) begin
                    m_arready = 1'b1; have_ar = 1'b1; ar_idx = m_araddr[4:2];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare newly logged writes against exp_q
    task automatic sb_drain(input string tag);
        int n;
        n = exp_q.size();
        check_eq({tag, "_count"}, got_q.size() - got_rd, n);
        for (int i = 0; i < n; i++) begin
            if (got_rd < got_q.size()) begin
                check_eq(tag, {21'd0, got_q[got_rd]}, {21'd0, exp_q[i]});
                got_rd++;
            end
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    task automatic push_cfg(input logic [15:0] div, input logic [7:0] lcr);
        exp_q.push_back({3'd3, 8'h80 | lcr});
        exp_q.push_back({3'd0, div[7:0]});
        exp_q.push_back({3'd1, div[15:8]});
        exp_q.push_back({3'd3, lcr & 8'h7F});
        exp_q.push_back({3'd2, 8'h07});
        exp_q.push_back({3'd1, 8'h00});
    endtask

    task automatic pulse_cfg(input logic [15:0] div, input logic [7:0] lcr);
        cfg_divisor = div; cfg_lcr = lcr; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_bad = 0; tx_pulses = 0; got_rd = 0;
        rst = 1'b1; cfg_start = 1'b0; cfg_divisor = 16'h0; cfg_lcr = 8'h0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        lsr_val = 8'h00; rbr_val = 8'h00; next_bresp = 2'b00;
        aw_delay = 0; w_delay = 0; b_delay = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check_eq("rst_axi", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        check_eq("rst_status", {cfg_done, busy, tx_ready, rx_valid}, 4'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_err", {lsr_err, bus_err}, 5'b0);
        check_eq("rst_state", dbg_state, 3'd0);

        // configuration sequence
        push_cfg(16'h0145, 8'h03);
        pulse_cfg(16'h0145, 8'h03);
        for (int i = 0; i < 400 && !cfg_done; i++) @(negedge clk);
        check_eq("cfg_done", cfg_done, 1'b1);
        check_eq("cfg_done_after_6", got_q.size(), 6);
        sb_drain("cfg_wr");

        // tx byte
        lsr_val = 8'h60; tx_data = 8'hA5; tx_valid = 1'b1; t0 = tx_pulses;
        for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
        tx_valid = 1'b0; l0 = lsr_reads;
        repeat (30) @(negedge clk);
        check_eq("tx_pulses", tx_pulses - t0, 1);
        check_eq("tx_next_poll", lsr_reads > l0, 1'b1);
        exp_q.push_back({3'd0, 8'hA5});
        sb_drain("tx_wr");

        // handshake skew: W first, AW three cycles later, B two cycles after
        w_delay = 0; aw_delay = 3; b_delay = 2;
        a0 = aw_beats; w0 = w_beats; busy_low = 0;
        tx_data = 8'h5A; tx_valid = 1'b1;
        for (int i = 0; i < 200 && !m_awvalid; i++) @(negedge clk);
        for (int i = 0; i < 50 && !tx_ready; i++) begin
            if (!busy) busy_low++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check_eq("skew_tx_ready", tx_ready, 1'b1);
        repeat (10) @(negedge clk);
        aw_delay = 0; b_delay = 0;
        check_eq("skew_busy_low", busy_low, 0);
        check_eq("skew_aw_beats", aw_beats - a0, 1);
        check_eq("skew_w_beats", w_beats - w0, 1);
        exp_q.push_back({3'd0, 8'h5A});
        sb_drain("skew_wr");

        // rx with back-pressure
        lsr_val = 8'h61; rbr_val = 8'h3C; rx_ready = 1'b0;
        for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
        check_eq("rx_valid", rx_valid, 1'b1);
        check_eq("rx_data", rx_data, 8'h3C);
        repeat (2) @(negedge clk);
        r0 = rbr_reads; l0 = lsr_reads;
        repeat (60) @(negedge clk);
        check_eq("rx_hold_no_rbr", rbr_reads - r0, 0);
        check_eq("rx_hold_polls", lsr_reads > l0 + 2, 1'b1);
        check_eq("rx_hold_valid", rx_valid, 1'b1);
        rbr_val = 8'hC3; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("rx_cleared", rx_valid, 1'b0);
        for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
        check_eq("rx_data2", rx_data, 8'hC3);
        lsr_val = 8'h00; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rx_idle", rx_valid, 1'b0);

        // sticky LSR errors
        lsr_val = 8'h0A;
        repeat (40) @(negedge clk);
        check_eq("lsr_err", lsr_err, 4'b0101);
        lsr_val = 8'h00;
        repeat (20) @(negedge clk);
        check_eq("lsr_err_sticky", lsr_err, 4'b0101);

        // SLVERR on a THR write
        lsr_val = 8'h60; next_bresp = 2'b10; tx_data = 8'h11; tx_valid = 1'b1; t0 = tx_pulses;
        for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
        tx_valid = 1'b0; next_bresp = 2'b00;
        repeat (5) @(negedge clk);
        check_eq("bus_err", bus_err, 1'b1);
        check_eq("err_tx_pulses", tx_pulses - t0, 1);
        exp_q.push_back({3'd0, 8'h11});
        sb_drain("err_wr");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("err_clr", {lsr_err, bus_err}, 5'b0);

        // restart during an RBR read
        lsr_val = 8'h61; rbr_val = 8'h77;
        for (int i = 0; i < 200 && !(m_arvalid && m_araddr[4:2] == 3'd0); i++) @(negedge clk);
        check_eq("restart_rbr_seen", m_arvalid, 1'b1);
        lsr_val = 8'h00;
        push_cfg(16'h1234, 8'h1B);
        pulse_cfg(16'h1234, 8'h9B);
        check_eq("restart_done_clr", cfg_done, 1'b0);
        for (int i = 0; i < 400 && !cfg_done; i++) @(negedge clk);
        check_eq("restart_cfg_done", cfg_done, 1'b1);
        check_eq("restart_rx", {rx_valid, rx_data}, {1'b1, 8'h77});
        sb_drain("restart_wr");
        check_eq("wdata_format", wfmt_bad, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
